// File: rtl/cb_pkg.sv
// Core bus channel bundles shared by the read arbiter and its neighbours.
// Master-to-slave (mosi) carries requests; slave-to-master (miso) carries responses.
package cb_pkg;

    typedef struct packed {
        logic [31:0] wr_addr;
        logic [2:0]  wr_size;
        logic        wr_addr_valid;
        logic [31:0] wr_data;
        logic [3:0]  wr_strobe;
        logic        wr_data_valid;
        logic        wr_resp_ready;
        logic [31:0] rd_addr;
        logic [2:0]  rd_size;
        logic        rd_addr_valid;
        logic        rd_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        wr_addr_ready;
        logic        wr_data_ready;
        logic [1:0]  wr_resp;
        logic        wr_resp_valid;
        logic        rd_addr_ready;
        logic [31:0] rd_data;
        logic [1:0]  rd_resp;
        logic        rd_valid;
    } s_cb_miso_t;

endpackage

// File: rtl/cb_rd_arbiter.sv
// Shares one core bus between fetch and LSU read requesters; writes come only from the LSU.
// Read responses are returned in order using a FIFO of source IDs (0 = instr, 1 = data).
module cb_rd_arbiter
    import cb_pkg::*;
#(
    parameter int unsigned MAX_OT     = 4,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  s_cb_mosi_t                instr_cb_mosi_i,
    output s_cb_miso_t                instr_cb_miso_o,
    input  s_cb_mosi_t                data_cb_mosi_i,
    output s_cb_miso_t                data_cb_miso_o,
    output s_cb_mosi_t                cb_mosi_o,
    input  s_cb_miso_t                cb_miso_i,
    output logic [$clog2(MAX_OT):0]   ot_cnt_o,
    output logic                      err_o
);

    localparam int unsigned PtrW = $clog2(MAX_OT);
    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [PtrW:0]   CntOne = 1;
    localparam logic [PtrW:0]   CntMax = (PtrW+1)'(MAX_OT);

    typedef enum logic [1:0] {ArbIdle, ArbLockI, ArbLockD} arb_state_e;

    arb_state_e      state_q;
    logic            last_ff;
    logic            id_q [MAX_OT];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            err_q;

    logic        fifo_full, fifo_empty, head_id, head_rd_ready;
    logic        gnt_any, gnt_id, gnt_valid;
    logic [31:0] gnt_addr;
    logic [2:0]  gnt_size;
    logic        accept, pop, orphan;

    // Instr write channel is not routed anywhere.
    logic unused_instr_wr;
    assign unused_instr_wr = ^{instr_cb_mosi_i.wr_addr, instr_cb_mosi_i.wr_size,
                               instr_cb_mosi_i.wr_addr_valid, instr_cb_mosi_i.wr_data,
                               instr_cb_mosi_i.wr_strobe, instr_cb_mosi_i.wr_data_valid,
                               instr_cb_mosi_i.wr_resp_ready};

    always_comb begin
        fifo_full  = (cnt_q == CntMax);
        fifo_empty = (cnt_q == '0);
        head_id    = id_q[rd_ptr_q];
        head_rd_ready = head_id ? data_cb_mosi_i.rd_ready : instr_cb_mosi_i.rd_ready;

        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        case (state_q)
            ArbLockI: gnt_any = 1'b1;
            ArbLockD: begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
            default: begin
                if (instr_cb_mosi_i.rd_addr_valid && data_cb_mosi_i.rd_addr_valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = (FIXED_PRIO != 0) ? 1'b1 : ~last_ff;
                end else if (instr_cb_mosi_i.rd_addr_valid) begin
                    gnt_any = 1'b1;
                end else if (data_cb_mosi_i.rd_addr_valid) begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
            end
        endcase
        // A full ID FIFO blocks the address channel outright, even if a pop is in flight.
        if (fifo_full) gnt_any = 1'b0;

        gnt_addr  = gnt_id ? data_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr;
        gnt_size  = gnt_id ? data_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size;
        gnt_valid = gnt_id ? data_cb_mosi_i.rd_addr_valid : instr_cb_mosi_i.rd_addr_valid;

        accept = gnt_any && gnt_valid && cb_miso_i.rd_addr_ready;
        pop    = !fifo_empty && cb_miso_i.rd_valid && head_rd_ready;
        orphan = fifo_empty && cb_miso_i.rd_valid;
    end

    always_comb begin
        cb_mosi_o               = data_cb_mosi_i;
        cb_mosi_o.rd_addr       = gnt_any ? gnt_addr : '0;
        cb_mosi_o.rd_size       = gnt_any ? gnt_size : '0;
        cb_mosi_o.rd_addr_valid = gnt_any && gnt_valid;
        // Orphan responses are drained rather than left stalling the bus.
        cb_mosi_o.rd_ready      = fifo_empty ? 1'b1 : head_rd_ready;

        instr_cb_miso_o               = '0;
        instr_cb_miso_o.rd_addr_ready = gnt_any && !gnt_id && cb_miso_i.rd_addr_ready;
        if (!fifo_empty && !head_id) begin
            instr_cb_miso_o.rd_data  = cb_miso_i.rd_data;
            instr_cb_miso_o.rd_resp  = cb_miso_i.rd_resp;
            instr_cb_miso_o.rd_valid = cb_miso_i.rd_valid;
        end

        data_cb_miso_o               = '0;
        data_cb_miso_o.wr_addr_ready = cb_miso_i.wr_addr_ready;
        data_cb_miso_o.wr_data_ready = cb_miso_i.wr_data_ready;
        data_cb_miso_o.wr_resp       = cb_miso_i.wr_resp;
        data_cb_miso_o.wr_resp_valid = cb_miso_i.wr_resp_valid;
        data_cb_miso_o.rd_addr_ready = gnt_any && gnt_id && cb_miso_i.rd_addr_ready;
        if (!fifo_empty && head_id) begin
            data_cb_miso_o.rd_data  = cb_miso_i.rd_data;
            data_cb_miso_o.rd_resp  = cb_miso_i.rd_resp;
            data_cb_miso_o.rd_valid = cb_miso_i.rd_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ArbIdle;
            last_ff  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= orphan;
            if (accept) begin
                id_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q       <= wr_ptr_q + PtrOne;
                last_ff        <= gnt_id;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CntOne;
                2'b01:   cnt_q <= cnt_q - CntOne;
                default: cnt_q <= cnt_q;
            endcase
            if (!fifo_full) begin
                case (state_q)
                    ArbIdle: begin
                        if (gnt_any && gnt_valid && !cb_miso_i.rd_addr_ready)
                            state_q <= gnt_id ? ArbLockD : ArbLockI;
                    end
                    default: if (accept) state_q <= ArbIdle;
                endcase
            end
        end
    end

    assign ot_cnt_o = cnt_q;
    assign err_o    = err_q;

endmodule
